t07_tft_req_queue: RTL and testbench

Request queue sitting directly upstream of the SPI TFT transmitter (`t07_spi_tft`). It accepts (address, data) display write requests from the memory-mapped bus side, buffers them in a small FIFO, and presents them one at a time to the transmitter using its `wi` / `ack` handshake. This lets the CPU post display writes without stalling on each serial transfer, and a watchdog keeps the queue from hanging on a missing `ack`.

---
 rtl/t07_tft_req_queue.sv | 102 ++++++++++
 tb/tb_t07_tft_req_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/t07_tft_req_queue.sv
// Request FIFO in front of the SPI TFT transmitter.
// Buffers (address, data) writes and replays them over the wi/ack handshake.
module t07_tft_req_queue #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   output logic        full,
   output logic        busy,
   output logic        overflow,
   output logic        timeout_err,
   output logic        wi,
   output logic [31:0] address,
   output logic [31:0] data,
   input  logic        ack
);

   localparam int AW = $clog2(DEPTH);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;
   logic [1:0]    state;
   logic [WW-1:0] wdog;
   logic          push;
   logic          pop;
   logic          expire;

   assign full   = (count == FULL_CNT);
   assign busy   = (count != '0) || (state != S_IDLE);
   assign expire = (wdog == WD_LAST);
   assign push   = wr_en && !full;
   assign pop    = (state == S_SEND) && (ack || expire);

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= {wr_addr, wr_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         state       <= S_IDLE;
         wdog        <= '0;
         wi          <= 1'b0;
         address     <= '0;
         data        <= '0;
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_en && full) overflow <= 1'b1;

         case (state)
            S_IDLE: begin
               if (count != '0) begin
                  address <= mem[head][63:32];
                  data    <= mem[head][31:0];
                  wi      <= 1'b1;
                  wdog    <= '0;
                  state   <= S_SEND;
               end
            end
            S_SEND: begin
               if (ack) begin
                  wi    <= 1'b0;
                  state <= S_GAP;
               end else if (expire) begin
                  // watchdog drop: entry is discarded as if acknowledged
                  wi          <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= S_GAP;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            S_GAP:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_t07_tft_req_queue.sv
// Scoreboard bench for t07_tft_req_queue (DEPTH=4, TIMEOUT=8).
// Accepted pushes queue their expected transfer; a monitor checks each wi rise.
module tb_t07_tft_req_queue;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        full;
   logic        busy;
   logic        overflow;
   logic        timeout_err;
   logic        wi;
   logic [31:0] address;
   logic [31:0] data;
   logic        ack;

   int passed;
   int total;
   logic [63:0] sb [$];

   t07_tft_req_queue #(.DEPTH(4), .TIMEOUT(8)) dut (
      .clk(clk),
      .rst(rst),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .full(full),
      .busy(busy),
      .overflow(overflow),
      .timeout_err(timeout_err),
      .wi(wi),
      .address(address),
      .data(data),
      .ack(ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input bit accept);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      if (accept) sb.push_back({a, d});
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic wait_ack();
      int n;
      n = 0;
      while (!wi && n < 20) begin
         tick();
         n++;
      end
      if (!wi) chk("wait_wi_timeout", 64'(wi), 64'd1);
      else pulse_ack();
   endtask

   // monitor: every rising wi must match the oldest outstanding request
   initial begin
      logic        wi_q;
      logic [63:0] exp;
      wi_q = 1'b0;
      forever begin
         @(negedge clk);
         if (wi && !wi_q) begin
            if (sb.size() == 0) begin
               chk("unexpected_wi", {address, data}, 64'h0);
            end else begin
               exp = sb.pop_front();
               chk("xfer", {address, data}, exp);
            end
         end
         wi_q = wi;
      end
   end

   initial begin
      int n;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_wi", 64'(wi), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_flags", {62'd0, overflow, timeout_err}, 64'd0);
      chk("rst_addr_data", {address, data}, 64'd0);

      // single write
      push(32'h0052_929D, 32'h003E_2244, 1'b1);
      chk("lat_wi_low", 64'(wi), 64'd0);
      tick();
      chk("lat_wi_high", 64'(wi), 64'd1);
      repeat (4) tick();
      pulse_ack();
      chk("ack_wi_low", 64'(wi), 64'd0);
      chk("gap_busy", 64'(busy), 64'd1);
      tick();
      chk("idle_busy", 64'(busy), 64'd0);

      // fill and overflow
      push(32'hA000_0001, 32'hD000_0001, 1'b1);
      push(32'hA000_0002, 32'hD000_0002, 1'b1);
      push(32'hA000_0003, 32'hD000_0003, 1'b1);
      chk("full_3", 64'(full), 64'd0);
      push(32'hA000_0004, 32'hD000_0004, 1'b1);
      chk("full_4", 64'(full), 64'd1);
      chk("ovf_before", 64'(overflow), 64'd0);
      push(32'hA000_0005, 32'hD000_0005, 1'b0);
      chk("ovf_after", 64'(overflow), 64'd1);
      for (int i = 0; i < 4; i++) begin
         pulse_ack();
         chk("fill_gap0", 64'(wi), 64'd0);
         tick();
         chk("fill_gap1", 64'(wi), 64'd0);
         tick();
         chk("fill_next", 64'(wi), (i < 3) ? 64'd1 : 64'd0);
      end
      chk("fill_idle", 64'(busy), 64'd0);

      // watchdog
      chk("to_before", 64'(timeout_err), 64'd0);
      push(32'hB000_0001, 32'hC000_0001, 1'b1);
      tick();
      n = 0;
      while (wi && n < 20) begin
         tick();
         n++;
      end
      chk("wd_len", 64'(n), 64'd8);
      chk("to_set", 64'(timeout_err), 64'd1);
      chk("wd_gap_busy", 64'(busy), 64'd1);
      tick();
      chk("wd_empty", 64'(busy), 64'd0);
      push(32'hB000_0002, 32'hC000_0002, 1'b1);
      wait_ack();
      tick();
      chk("wd_after_idle", 64'(busy), 64'd0);
      chk("to_sticky", 64'(timeout_err), 64'd1);

      // simultaneous push and pop, pointers wrap
      push(32'hF000_0001, 32'hE000_0001, 1'b1);
      push(32'hF000_0002, 32'hE000_0002, 1'b1);
      ack = 1'b1;
      push(32'hF000_0003, 32'hE000_0003, 1'b1);
      ack = 1'b0;
      chk("sim_full0", 64'(full), 64'd0);
      push(32'hF000_0004, 32'hE000_0004, 1'b1);
      chk("sim_full1", 64'(full), 64'd0);
      push(32'hF000_0005, 32'hE000_0005, 1'b1);
      chk("sim_full2", 64'(full), 64'd1);
      repeat (4) wait_ack();
      tick();
      chk("sim_idle", 64'(busy), 64'd0);

      // spurious ack in IDLE and in GAP
      push(32'h1111_0001, 32'h2222_0001, 1'b1);
      ack = 1'b1;
      push(32'h1111_0002, 32'h2222_0002, 1'b1);
      ack = 1'b0;
      chk("sp_idle_wi", 64'(wi), 64'd1);
      pulse_ack();
      pulse_ack();
      tick();
      chk("sp_gap_wi", 64'(wi), 64'd1);
      pulse_ack();
      tick();
      chk("sp_idle", 64'(busy), 64'd0);

      // reset mid-transfer with entries queued
      push(32'h3333_0001, 32'h4444_0001, 1'b1);
      push(32'h3333_0002, 32'h4444_0002, 1'b1);
      push(32'h3333_0003, 32'h4444_0003, 1'b1);
      chk("pre_rst_wi", 64'(wi), 64'd1);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      sb.delete();
      chk("mrst_wi", 64'(wi), 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_flags", {61'd0, full, overflow, timeout_err}, 64'd0);
      chk("mrst_addr_data", {address, data}, 64'd0);
      repeat (12) tick();
      chk("mrst_quiet", {62'd0, wi, busy}, 64'd0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
